// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants and glyph table for the seven-segment scanner
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low glyphs in {g,f,e,d,c,b,a} order
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational 4-bit value to active-low seven-segment glyph
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (value)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed, double-buffered 4-digit display scanner
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_i,
    input  logic        blank_lz_i,
    input  logic        load_i,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   pend_digits, act_digits;
    logic [3:0]    pend_dp, act_dp;
    logic          pend_blz, act_blz;

    logic       slot_wrap, frame_boundary, in_blank;
    logic [3:0] cur_value;
    logic [6:0] cur_glyph;
    logic       cur_blank;
    logic       blank3, blank2, blank1;

    assign slot_wrap      = (slot_cnt == CNT_LAST);
    assign frame_boundary = slot_wrap && (digit_idx == 2'd3);
    assign in_blank       = int'(slot_cnt) < BLANK_CYC;
    assign cur_value      = act_digits[digit_idx*4 +: 4];

    // Leading-zero suppression ripples down from the most significant digit
    assign blank3 = act_blz && (act_digits[15:12] == 4'h0);
    assign blank2 = blank3  && (act_digits[11:8]  == 4'h0);
    assign blank1 = blank2  && (act_digits[7:4]   == 4'h0);

    always_comb begin
        cur_blank = 1'b0;
        case (digit_idx)
            2'd3:    cur_blank = blank3;
            2'd2:    cur_blank = blank2;
            2'd1:    cur_blank = blank1;
            default: cur_blank = 1'b0;
        endcase
    end

    seg_decoder u_seg_decoder (
        .value (cur_value),
        .glyph (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
        end
    end

    // A load landing on the boundary cycle goes straight into the active buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blz    <= 1'b0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_blz     <= 1'b0;
        end else begin
            if (load_i) begin
                pend_digits <= digits_i;
                pend_dp     <= dp_i;
                pend_blz    <= blank_lz_i;
            end
            if (frame_boundary) begin
                act_digits <= load_i ? digits_i   : pend_digits;
                act_dp     <= load_i ? dp_i       : pend_dp;
                act_blz    <= load_i ? blank_lz_i : pend_blz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an_n       <= AN_OFF;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_boundary;
            if (in_blank) begin
                an_n  <= AN_OFF;
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
            end else begin
                an_n  <= ~(4'b0001 << digit_idx);
                seg_n <= cur_blank ? SEG_BLANK : cur_glyph;
                dp_n  <= ~act_dp[digit_idx];
            end
        end
    end

endmodule
